// File: rtl/vr_pkg.sv
// vr_pkg: flit type codes, type-field position and VC state shared by the VC router blocks.
package vr_pkg;
    localparam int FLIT_DATA_WIDTH = 32;
    localparam int FLIT_TYPE_W = 2;

    typedef enum logic [FLIT_TYPE_W-1:0] {
        FLIT_BODY     = 2'b00,
        FLIT_HEAD     = 2'b01,
        FLIT_TAIL     = 2'b10,
        FLIT_HEADTAIL = 2'b11
    } flit_type_t;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ACTIVE = 2'd1,
        VC_DRAIN  = 2'd2
    } vc_state_t;
endpackage

// File: rtl/vc_input_unit_if.sv
// vc_input_unit_if: flit input, pop request and per-VC status bundle of one router input port.
interface vc_input_unit_if #(
    parameter int NUM_VC = 4,
    parameter int FLIT_WIDTH = vr_pkg::FLIT_DATA_WIDTH
);
    localparam int VCW = $clog2(NUM_VC);
    logic [FLIT_WIDTH-1:0]        in_data;
    logic                         in_valid;
    logic [VCW-1:0]               in_vc;
    logic                         in_ready;
    logic                         rd_en;
    logic [VCW-1:0]               rd_vc;
    logic [NUM_VC*FLIT_WIDTH-1:0] vc_head_data;
    logic [NUM_VC-1:0]            vc_valid;
    logic [NUM_VC-1:0]            vc_idle;
    logic [NUM_VC-1:0]            upstr_credit;
    logic                         proto_err;

    modport master (
        output in_data, in_valid, in_vc, rd_en, rd_vc,
        input  in_ready, vc_head_data, vc_valid, vc_idle, upstr_credit, proto_err
    );
    modport slave (
        input  in_data, in_valid, in_vc, rd_en, rd_vc,
        output in_ready, vc_head_data, vc_valid, vc_idle, upstr_credit, proto_err
    );
endinterface

// File: rtl/vc_fifo.sv
// vc_fifo: single-VC flit FIFO; a push and pop in the same cycle are legal even when full.
module vc_fifo
    import vr_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int FLIT_WIDTH = FLIT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_push,
    input  logic                      i_pop,
    input  logic [FLIT_WIDTH-1:0]     i_data,
    output logic [FLIT_WIDTH-1:0]     o_data,
    output logic                      o_full,
    output logic                      o_empty,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);
    logic [FLIT_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    always_ff @(posedge clk)
        if (i_push) r_mem[r_wr_ptr] <= i_data;

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign o_count = r_count;
endmodule

// File: rtl/vc_input_unit.sv
// vc_input_unit: per-port input unit holding NUM_VC flit FIFOs with wormhole state,
// credit return, optional local VC allocation and sticky protocol-error detection.
module vc_input_unit
    import vr_pkg::*;
#(
    parameter int NUM_VC = 4,
    parameter int DEPTH = 4,
    parameter int FLIT_WIDTH = FLIT_DATA_WIDTH,
    parameter bit ALLOC_LOCAL = 1'b0
) (
    input  logic           clk,
    input  logic           reset,
    vc_input_unit_if.slave bus
);
    localparam int VCW = $clog2(NUM_VC);
    localparam int CW = $clog2(DEPTH) + 1;

    flit_type_t        w_type;
    logic              w_is_head;
    logic [VCW-1:0]    w_free_vc;
    logic [VCW-1:0]    w_tgt;
    logic [VCW-1:0]    r_cur_vc;
    logic              r_open;
    logic              r_err;
    logic              w_ready;
    logic              w_ok;
    logic              w_take;
    logic              w_wr;
    logic [NUM_VC-1:0] w_full;
    logic [NUM_VC-1:0] w_empty;
    logic [NUM_VC-1:0] w_idle;
    logic [NUM_VC-1:0] w_pop;
    logic [NUM_VC-1:0] w_push;
    logic [NUM_VC-1:0] r_credit;

    assign w_type    = flit_type_t'(bus.in_data[FLIT_WIDTH-1 -: FLIT_TYPE_W]);
    assign w_is_head = w_type == FLIT_HEAD || w_type == FLIT_HEADTAIL;

    always_comb begin
        w_free_vc = '0;
        for (int i = NUM_VC - 1; i >= 0; i--)
            if (w_idle[i]) w_free_vc = VCW'(i);
    end

    assign w_tgt   = ALLOC_LOCAL ? (w_is_head ? w_free_vc : r_cur_vc) : bus.in_vc;
    assign w_ready = ALLOC_LOCAL ? (r_open ? (!w_full[r_cur_vc] || w_pop[r_cur_vc]) : |w_idle) : 1'b1;
    // A head must open an idle VC; body/tail must continue a packet; space may come from a same-cycle pop.
    assign w_ok    = (w_is_head ? w_idle[w_tgt] : !w_idle[w_tgt])
                   && (!ALLOC_LOCAL || (w_is_head != r_open))
                   && (!w_full[w_tgt] || w_pop[w_tgt]);
    assign w_take  = bus.in_valid && w_ready;
    assign w_wr    = w_take && w_ok;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        logic [CW-1:0] w_count;
        vc_state_t     r_state;
        assign w_pop[v]  = bus.rd_en && bus.rd_vc == VCW'(v) && !w_empty[v];
        assign w_push[v] = w_wr && w_tgt == VCW'(v);
        assign w_idle[v] = r_state == VC_IDLE;
        vc_fifo #(.DEPTH(DEPTH), .FLIT_WIDTH(FLIT_WIDTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .i_push  (w_push[v]),
            .i_pop   (w_pop[v]),
            .i_data  (bus.in_data),
            .o_data  (bus.vc_head_data[v*FLIT_WIDTH +: FLIT_WIDTH]),
            .o_full  (w_full[v]),
            .o_empty (w_empty[v]),
            .o_count (w_count)
        );
        always_ff @(posedge clk or posedge reset)
            if (reset) r_state <= VC_IDLE;
            else if (w_push[v] && r_state == VC_IDLE) r_state <= w_type == FLIT_HEADTAIL ? VC_DRAIN : VC_ACTIVE;
            else if (w_push[v] && r_state == VC_ACTIVE && w_type == FLIT_TAIL) r_state <= VC_DRAIN;
            else if (r_state == VC_DRAIN && w_pop[v] && !w_push[v] && w_count == CW'(1)) r_state <= VC_IDLE;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_open   <= 1'b0;
            r_cur_vc <= '0;
            r_credit <= '0;
            r_err    <= 1'b0;
        end else begin
            r_credit <= w_pop;
            r_err    <= r_err | (w_take && !w_ok);
            if (w_wr && w_is_head) begin
                r_cur_vc <= w_free_vc;
                r_open   <= w_type == FLIT_HEAD;
            end else if (w_wr && w_type == FLIT_TAIL) r_open <= 1'b0;
        end

    assign bus.in_ready     = w_ready;
    assign bus.vc_valid     = ~w_empty;
    assign bus.vc_idle      = w_idle;
    assign bus.upstr_credit = r_credit;
    assign bus.proto_err    = r_err;
endmodule
